sram_chip_model: RTL
====================

Name: sram_chip_model

Overview:
- Synthesizable responder for the external 16-bit asynchronous-style SRAM port: the chip side of the bus that the SRAM controller drives.
- Decodes SRAMAddress/SRAMWE/SRAMOE/SRAMCE/SRAMUB/SRAMLB.
- Stores halfwords with byte-lane masking and returns read data on the shared SRAMData bus after a configurable latency.
- Used in place of the board SRAM for simulation and for on-FPGA memory self-test builds.

Parameters:
- ADDR_WIDTH, 18, width of SRAMAddress.
- DEPTH_LOG2, 18, log2 of implemented halfword count; address bits at and above DEPTH_LOG2 are ignored (aliasing).
- READ_LATENCY, 1, clock edges from read issue to data driven on SRAMData; legal range 1..4.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, synchronous, active-high
- SRAMAddress  input  ADDR_WIDTH  halfword address
- SRAMData  inout  16  shared data bus
- SRAMUB  input  1  upper byte enable, active-low
- SRAMLB  input  1  lower byte enable, active-low
- SRAMWE  input  1  write enable, active-low
- SRAMOE  input  1  output enable, active-low
- SRAMCE  input  1  chip enable, active-low
- readCount  output  16  number of read issues since reset, wraps at 16'hFFFF
- writeCount  output  16  number of write cycles since reset, wraps
- busConflict  output  1  sticky contention flag (see Optional Feature)

Behaviour:
- Reset is synchronous to clk, active-high: clears the read pipeline valid bits, readCount, writeCount and busConflict; SRAMData is Z from the cycle after rst is sampled. Memory array contents are NOT cleared.
- Index = SRAMAddress[DEPTH_LOG2-1:0]; a higher-order address wraps modulo 2^DEPTH_LOG2.
- Write cycle = CE=0 and WE=0 at a rising edge:
  - mem[index][7:0] <= SRAMData[7:0] if LB=0.
  - mem[index][15:8] <= SRAMData[15:8] if UB=0.
  - Both high: no array change, but writeCount still increments.
  - OE is ignored during a write.
- Read issue = CE=0, WE=1, OE=0 at a rising edge:
  - Captures mem[index] (contents as of before that edge) plus the UB/LB values into pipeline stage 1; readCount increments.
  - Pipeline is READ_LATENCY stages deep and advances every edge unconditionally; there is no stall.
- Drive rule, combinational: SRAMData[15:8] = last-stage data if last stage is valid, its captured UB=0, and the current CE=0, WE=1, OE=0; otherwise Z. SRAMData[7:0] follows the same rule with LB.
- READ_LATENCY=1: address in cycle N gives data valid during cycle N+1, matching a controller that sets the high-half address in the cycle after the low-half address and samples the low half then.
- Back-to-back reads: one result per cycle, fully pipelined.
- Write at edge N, read of the same index issued at edge N+1: returns the new data.
- CE=1: no write, no issue, bus Z. Pipeline still drains; a valid last stage is dropped if CE=1 when it arrives.
- Reset asserted while reads are in flight: in-flight data is discarded and never driven.
- Counter increments and reset in the same edge: reset wins.

Optional Feature:
- Macro: SRAM_CHIP_MODEL_CONFLICT_CHECK_EN.
- Defined: busConflict is set at any rising edge where CE=0, WE=0 and the last pipeline stage is valid (the initiator is writing while a read result is due). The flag is sticky until rst. The write still commits, and the model does not drive the bus in that cycle.
- Undefined: busConflict is tied 0 and no detection logic is built.

Test Plan:
- Full write/read: write 16'h1234 to addr 18'h00010 (UB=LB=0), then read issue at 18'h00010 → SRAMData=16'h1234 in the following cycle; writeCount=1, readCount=1.
- Byte lane: after the first scenario, write 16'hAB00 with UB=0, LB=1 to 18'h00010, then read → 16'hAB34; a read with LB=1 only → SRAMData[7:0]=Z, [15:8]=8'hAB.
- Latency: READ_LATENCY=3, reads issued to addrs 0,1,2 on consecutive edges holding 16'h0A0A/16'h0B0B/16'h0C0C → data appears on cycles N+3..N+5 in order, bus Z before that.
- Alias: DEPTH_LOG2=10, write 16'hBEEF to 18'h00400 → read of 18'h00000 returns 16'hBEEF.
- Reset mid-read: issue a read with READ_LATENCY=2 and assert rst on the next edge → SRAMData stays Z, readCount=0, memory retains prior data.
- Conflict (macro defined): issue a read, then hold WE=0 on the next edge → busConflict=1 and remains 1 until rst; macro undefined → busConflict=0.

Source files
------------

// File: rtl/sram_chip_model.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_chip_model: chip side of a 16-bit async-style SRAM bus with byte    |
// | lanes and a pipelined read path. Macro SRAM_CHIP_MODEL_CONFLICT_CHECK_EN |
// | builds sticky write-vs-read-result contention detection.   Rev 1.0      |
// +--------------------------------------------------------------------------+
module sram_chip_model #(
  parameter int ADDR_WIDTH   = 18,
  parameter int DEPTH_LOG2   = 18,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] SRAMAddress,
  inout  wire  [15:0]           SRAMData,
  input  logic                  SRAMUB,
  input  logic                  SRAMLB,
  input  logic                  SRAMWE,
  input  logic                  SRAMOE,
  input  logic                  SRAMCE,
  output logic [15:0]           readCount,
  output logic [15:0]           writeCount,
  output logic                  busConflict
);

  localparam int C_DEPTH = 1 << DEPTH_LOG2;
  localparam int C_LAST  = READ_LATENCY - 1;

  logic [15:0]           mem_q [C_DEPTH];
  logic [DEPTH_LOG2-1:0] index_w;
  logic                  write_w;
  logic                  issue_w;
  logic                  unused_addr_w;

  logic [READ_LATENCY-1:0] vld_q;
  logic [READ_LATENCY-1:0] ub_q;
  logic [READ_LATENCY-1:0] lb_q;
  logic [15:0]             data_q [READ_LATENCY];

  logic [15:0] readCount_q, readCount_d;
  logic [15:0] writeCount_q, writeCount_d;
  logic        drive_ub_w, drive_lb_w;

  // Upper address bits are deliberately dropped so the array aliases.
  assign index_w       = SRAMAddress[DEPTH_LOG2-1:0];
  assign unused_addr_w = ^SRAMAddress;
  assign write_w       = !SRAMCE && !SRAMWE;
  assign issue_w       = !SRAMCE && SRAMWE && !SRAMOE;

  always_ff @(posedge clk) begin
    if (write_w) begin
      if (!SRAMLB) mem_q[index_w][7:0]  <= SRAMData[7:0];
      if (!SRAMUB) mem_q[index_w][15:8] <= SRAMData[15:8];
    end
  end

  // Payload stages carry no reset; only the valid bits need clearing.
  always_ff @(posedge clk) begin
    data_q[0] <= mem_q[index_w];
    ub_q[0]   <= SRAMUB;
    lb_q[0]   <= SRAMLB;
    for (int i = 1; i < READ_LATENCY; i++) begin
      data_q[i] <= data_q[i-1];
      ub_q[i]   <= ub_q[i-1];
      lb_q[i]   <= lb_q[i-1];
    end
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= issue_w;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  always_comb begin
    readCount_d  = readCount_q;
    writeCount_d = writeCount_q;
    if (issue_w) readCount_d  = readCount_q + 16'd1;
    if (write_w) writeCount_d = writeCount_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      readCount_q  <= 16'd0;
      writeCount_q <= 16'd0;
    end else begin
      readCount_q  <= readCount_d;
      writeCount_q <= writeCount_d;
    end
  end

  assign readCount  = readCount_q;
  assign writeCount = writeCount_q;

  // A due result is only presented while the initiator is still reading.
  assign drive_ub_w = vld_q[C_LAST] && !ub_q[C_LAST] && issue_w;
  assign drive_lb_w = vld_q[C_LAST] && !lb_q[C_LAST] && issue_w;

  assign SRAMData[15:8] = drive_ub_w ? data_q[C_LAST][15:8] : 8'hzz;
  assign SRAMData[7:0]  = drive_lb_w ? data_q[C_LAST][7:0]  : 8'hzz;

`ifdef SRAM_CHIP_MODEL_CONFLICT_CHECK_EN
  logic busConflict_q, busConflict_d;

  always_comb begin
    busConflict_d = busConflict_q;
    if (write_w && vld_q[C_LAST]) busConflict_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busConflict_q <= 1'b0;
    else     busConflict_q <= busConflict_d;
  end

  assign busConflict = busConflict_q;
`else
  assign busConflict = 1'b0;
`endif

endmodule
`default_nettype wire
